// File: rtl/exe_stage_md.sv
// exe_stage_md: EXE stage (ID->EXE register, alu, iterative mul/div, store lanes); ALIGN_CHECK_EN adds misalignment trap.
// Latency: 1 cycle for alu/mem ops, MUL_STAGES+1 for mul*, 32/DIV_STEP_BITS+2 for div/mod (2 on zero divisor).
// Backpressure: holds while mem_allowin is low or a mul/div is in flight; exe_allowin drops accordingly.
module exe_stage_md #(
    parameter int MUL_STAGES    = 2,
    parameter int DIV_STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_to_exe_valid,
    output logic        exe_allowin,
    input  logic [31:0] id_pc,
    input  logic [11:0] id_alu_op,
    input  logic [2:0]  id_md_op,
    input  logic [31:0] id_src1,
    input  logic [31:0] id_src2,
    input  logic [31:0] id_rkd,
    input  logic        id_res_from_mem,
    input  logic        id_mem_wr,
    input  logic [1:0]  id_mem_size,
    input  logic        id_rf_we,
    input  logic [4:0]  id_rf_waddr,
    input  logic        mem_allowin,
    output logic        exe_to_mem_valid,
    output logic [72:0] exe_to_mem_bus,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        exe_fwd_valid,
    output logic [4:0]  exe_fwd_waddr,
    output logic        exe_fwd_ready,
    output logic [31:0] exe_fwd_data,
    output logic        exe_ale
);
    localparam int DIV_ITERS = 32 / DIV_STEP_BITS;

    localparam logic [2:0] MD_NONE = 3'd0;
    localparam logic [2:0] MD_MULL = 3'd1;
    localparam logic [2:0] MD_MULH = 3'd2;
    localparam logic [2:0] MD_DIVS = 3'd4;
    localparam logic [2:0] MD_DIVU = 3'd5;
    localparam logic [2:0] MD_MODS = 3'd6;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_t;

    logic        exe_valid;
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [2:0]  md_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd;
    logic        res_from_mem;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        rf_we;
    logic [4:0]  rf_waddr;

    md_state_t   md_state;
    logic [5:0]  md_cnt;
    logic [31:0] md_result;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_dvs;
    logic        div_neg_q;
    logic        div_neg_r;

    logic        exe_readygo;
    logic        handoff;
    logic [31:0] alu_result;
    logic [31:0] exe_result;
    logic        mem_access;
    logic        ale;
    logic        bus_rf_we;

    // ---------------- alu (one-hot op) ----------------
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = alu_result | (src1 + src2);
        if (alu_op[1])  alu_result = alu_result | (src1 - src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << src2[4:0]);
        if (alu_op[9])  alu_result = alu_result | (src1 >> src2[4:0]);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> src2[4:0]);
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    // ---------------- multiply: one 64-bit product, sign-extended only for mulh ----------------
    logic        mul_sext;
    logic [63:0] mul_prod;
    assign mul_sext = (md_op == MD_MULH);
    assign mul_prod = {{32{mul_sext & src1[31]}}, src1} * {{32{mul_sext & src2[31]}}, src2};

    // ---------------- restoring divide step on magnitudes ----------------
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [32:0] step_trial;
    always_comb begin
        step_rem   = div_rem;
        step_quo   = div_quo;
        step_trial = 33'd0;
        for (int i = 0; i < DIV_STEP_BITS; i++) begin
            step_trial = {step_rem, step_quo[31]};
            step_quo   = {step_quo[30:0], 1'b0};
            if (step_trial >= {1'b0, div_dvs}) begin
                step_trial  = step_trial - {1'b0, div_dvs};
                step_quo[0] = 1'b1;
            end
            step_rem = step_trial[31:0];
        end
    end

    logic        is_quo_op;
    logic [31:0] fix_quo;
    logic [31:0] fix_rem;
    assign is_quo_op = (md_op == MD_DIVS) || (md_op == MD_DIVU);
    assign fix_quo   = div_neg_q ? (32'd0 - div_quo) : div_quo;
    assign fix_rem   = div_neg_r ? (32'd0 - div_rem) : div_rem;

    logic id_div_signed;
    assign id_div_signed = (id_md_op == MD_DIVS) || (id_md_op == MD_MODS);

    // ---------------- handshake ----------------
    assign exe_readygo      = (md_op == MD_NONE) || (md_state == MD_DONE);
    assign exe_allowin      = !exe_valid || (exe_readygo && mem_allowin);
    assign handoff          = exe_valid && exe_readygo && mem_allowin;
    assign exe_to_mem_valid = exe_valid && exe_readygo;

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid    <= 1'b0;
            pc           <= 32'd0;
            alu_op       <= 12'd0;
            md_op        <= 3'd0;
            src1         <= 32'd0;
            src2         <= 32'd0;
            rkd          <= 32'd0;
            res_from_mem <= 1'b0;
            mem_wr       <= 1'b0;
            mem_size     <= 2'd0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            md_state     <= MD_IDLE;
            md_cnt       <= 6'd0;
            md_result    <= 32'd0;
            div_rem      <= 32'd0;
            div_quo      <= 32'd0;
            div_dvs      <= 32'd0;
            div_neg_q    <= 1'b0;
            div_neg_r    <= 1'b0;
        end else begin
            case (md_state)
                MD_MUL: begin
                    if (md_cnt == 6'(MUL_STAGES - 1)) begin
                        md_result <= (md_op == MD_MULL) ? mul_prod[31:0] : mul_prod[63:32];
                        md_state  <= MD_DONE;
                    end else begin
                        md_cnt <= md_cnt + 6'd1;
                    end
                end
                MD_DIV: begin
                    if (div_dvs == 32'd0) begin
                        md_result <= is_quo_op ? 32'hFFFF_FFFF : src1;
                        md_state  <= MD_DONE;
                    end else if (md_cnt == 6'(DIV_ITERS)) begin
                        md_result <= is_quo_op ? fix_quo : fix_rem;
                        md_state  <= MD_DONE;
                    end else begin
                        div_rem <= step_rem;
                        div_quo <= step_quo;
                        md_cnt  <= md_cnt + 6'd1;
                    end
                end
                MD_DONE: begin
                    if (handoff) md_state <= MD_IDLE;
                end
                default: ;
            endcase

            // A capture in the same cycle overrides the DONE->IDLE exit above.
            if (exe_allowin) begin
                exe_valid    <= id_to_exe_valid;
                pc           <= id_pc;
                alu_op       <= id_alu_op;
                md_op        <= id_md_op;
                src1         <= id_src1;
                src2         <= id_src2;
                rkd          <= id_rkd;
                res_from_mem <= id_res_from_mem;
                mem_wr       <= id_mem_wr;
                mem_size     <= id_mem_size;
                rf_we        <= id_rf_we;
                rf_waddr     <= id_rf_waddr;
                md_cnt       <= 6'd0;
                if (id_to_exe_valid && id_md_op != MD_NONE) begin
                    md_state  <= (id_md_op < MD_DIVS) ? MD_MUL : MD_DIV;
                    div_rem   <= 32'd0;
                    div_quo   <= (id_div_signed && id_src1[31]) ? (32'd0 - id_src1) : id_src1;
                    div_dvs   <= (id_div_signed && id_src2[31]) ? (32'd0 - id_src2) : id_src2;
                    div_neg_q <= id_div_signed && (id_src1[31] ^ id_src2[31]);
                    div_neg_r <= id_div_signed && id_src1[31];
                end else begin
                    md_state <= MD_IDLE;
                end
            end
        end
    end

    // ---------------- memory request and lanes ----------------
    assign mem_access = res_from_mem || mem_wr;
    assign exe_result = (md_op == MD_NONE) ? alu_result : md_result;

`ifdef ALIGN_CHECK_EN
    assign ale = exe_valid && mem_access &&
                 (((mem_size == 2'd1) && alu_result[0]) ||
                  ((mem_size == 2'd2) && (alu_result[1:0] != 2'd0)));
`else
    assign ale = 1'b0;
`endif

    assign exe_ale        = ale;
    assign bus_rf_we      = rf_we && !ale;
    assign data_sram_en   = exe_valid && mem_access && mem_allowin && !ale;
    assign data_sram_addr = alu_result;

    always_comb begin
        data_sram_we    = 4'd0;
        data_sram_wdata = rkd;
        case (mem_size)
            2'd0: data_sram_wdata = {4{rkd[7:0]}};
            2'd1: data_sram_wdata = {2{rkd[15:0]}};
            default: data_sram_wdata = rkd;
        endcase
        if (data_sram_en && mem_wr) begin
            case (mem_size)
                2'd0: data_sram_we = 4'b0001 << alu_result[1:0];
                2'd1: data_sram_we = alu_result[1] ? 4'b1100 : 4'b0011;
                default: data_sram_we = 4'b1111;
            endcase
        end
    end

    assign exe_to_mem_bus = {pc, res_from_mem, mem_size, bus_rf_we, rf_waddr, exe_result};

    assign exe_fwd_valid = exe_valid && bus_rf_we && (rf_waddr != 5'd0);
    assign exe_fwd_waddr = rf_waddr;
    assign exe_fwd_ready = exe_valid && exe_readygo && !res_from_mem;
    assign exe_fwd_data  = exe_result;
endmodule
